// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// State encoding, default reset PC and sequential PC step.
package fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_REQ  = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_HOLD = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/inst_fetch_if.sv
// Handshake bundles of the fetch stage: instruction memory side
// and decode side. The fetch stage is the master of both.
interface imem_if;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] PC;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Instruction;

    modport master (
        output Inst_Req_Valid, PC, Inst_Ready,
        input  Inst_Req_Ready, Inst_Valid, Instruction
    );
    modport slave (
        input  Inst_Req_Valid, PC, Inst_Ready,
        output Inst_Req_Ready, Inst_Valid, Instruction
    );
endinterface

interface if_id_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output if_valid, if_pc, if_inst,
        input  if_ready
    );
    modport slave (
        input  if_valid, if_pc, if_inst,
        output if_ready
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: redirect load wins over sequential increment.
// Increment wraps modulo 2^32.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: request / wait / hold FSM with redirect.
// Define FETCH_PERF_CNT_EN to add the fetch_cycles counter port.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.master      mem,
    if_id_if.master     dec,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cycles
`endif
);

    state_t      state_q;
    state_t      state_d;
    logic        drop_q;
    logic        drop_d;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_d;
    logic [31:0] if_inst_q;
    logic [31:0] if_inst_d;
    logic [31:0] pc;

    logic req_hs;
    logic rsp_hs;
    logic dec_hs;

    logic req_valid;
    logic inst_ready;
    logic out_valid;

    assign req_hs = (state_q == S_REQ) && mem.Inst_Req_Ready;
    assign rsp_hs = (state_q == S_WAIT) && mem.Inst_Valid;
    assign dec_hs = (state_q == S_HOLD) && dec.if_ready;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .inc     (dec_hs),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            drop_q    <= 1'b0;
            if_pc_q   <= RESET_PC;
            if_inst_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        unique case (state_q)
            S_REQ: begin
                if (req_hs) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                // A response racing a redirect is stale: drop it directly
                if (rsp_hs) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d   = S_HOLD;
                        if_pc_d   = pc;
                        if_inst_d = mem.Instruction;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || dec_hs) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        req_valid  = 1'b0;
        inst_ready = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            S_REQ:   req_valid  = ~rst;
            S_WAIT:  inst_ready = 1'b1;
            S_HOLD:  out_valid  = 1'b1;
            default: req_valid  = 1'b0;
        endcase
    end

    assign mem.Inst_Req_Valid = req_valid;
    assign mem.PC             = pc;
    assign mem.Inst_Ready     = inst_ready;
    assign dec.if_valid       = out_valid;
    assign dec.if_pc          = if_pc_q;
    assign dec.if_inst        = if_inst_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc_q;
    logic [31:0] fc_d;

    always_comb begin
        fc_d = fc_q;
        if ((state_q != S_HOLD) && (fc_q != 32'hFFFF_FFFF)) begin
            fc_d = fc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= 32'h0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign fetch_cycles = fc_q;
`endif

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the simple CPU. Holds the PC and issues requests to instruction memory over a valid/ready handshake. Presents each fetched instruction with its PC to the decode stage under a valid/ready handshake. Accepts redirects (jump/branch targets) from downstream and discards any stale in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- PC_STEP, 4, sequential PC increment in bytes
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- Inst_Req_Valid  output  1  fetch request valid
- Inst_Req_Ready  input  1  memory accepts request
- PC  output  32  fetch address; memory samples it only on the request-handshake cycle
- Inst_Valid  input  1  instruction response valid
- Inst_Ready  output  1  stage ready for response
- Instruction  input  32  response data
- if_valid  output  1  fetched instruction valid toward decode
- if_ready  input  1  decode accepts instruction
- if_pc  output  32  PC of presented instruction
- if_inst  output  32  presented instruction
- redirect_valid  input  1  single-cycle redirect pulse from downstream
- redirect_pc  input  32  redirect target
- fetch_cycles  output  32  perf counter (only with FETCH_PERF_CNT_EN)

## Operation
- States: S_REQ, S_WAIT, S_HOLD; all outputs registered or decoded from state only.
- S_REQ: Inst_Req_Valid=1, PC=pc_reg. On Inst_Req_Ready -> S_WAIT.
- S_WAIT: Inst_Ready=1. On Inst_Valid: if drop flag clear, capture Instruction into if_inst, pc_reg into if_pc -> S_HOLD; if drop flag set, discard, clear drop -> S_REQ.
- S_HOLD: if_valid=1. On if_ready: pc_reg += PC_STEP (mod 2^32, wraps silently) -> S_REQ.
- Redirect, all states, highest priority:
  - S_REQ, no handshake that cycle: pc_reg <= redirect_pc, stay S_REQ.
  - S_REQ with simultaneous Inst_Req_Ready: pc_reg <= redirect_pc, set drop, -> S_WAIT.
  - S_WAIT: pc_reg <= redirect_pc, set drop; if Inst_Valid same cycle, discard and -> S_REQ directly, drop stays clear.
  - S_HOLD: pc_reg <= redirect_pc, if_valid drops next cycle, -> S_REQ; simultaneous if_ready ignored (no increment).
- Redirect target alignment not checked.

## Timing
- Reset values: state S_REQ, pc_reg RESET_PC, Inst_Req_Valid 0 during reset then 1 first cycle after release, Inst_Ready 0, if_valid 0, if_pc RESET_PC, if_inst 0, drop 0, fetch_cycles 0.
- Minimum latency request to if_valid: 2 cycles (handshake edge -> S_WAIT; response edge -> S_HOLD).
- Back-to-back throughput: one instruction per 3 cycles minimum.
- if_pc/if_inst stable while if_valid=1 and no handshake/redirect.
- Reset mid-operation: immediate return to reset values; outstanding memory response after reset is not waited for (memory reset together).

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_cycles port present; counts every cycle with state != S_HOLD, saturating at 32'hFFFF_FFFF, cleared by rst.
- Undefined: port and counter absent; no other behavioural difference.

## Structure
- Package fetch_pkg: state encoding localparams (S_REQ/S_WAIT/S_HOLD, 2-bit), default RESET_PC, PC_STEP.
- Sub-module fetch_pc_reg: PC register with reset, increment and redirect-load inputs, redirect priority internal.

## Test plan
- Reset release, memory always ready, 1-cycle response, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, one instruction per 3 cycles.
- if_ready held 0 for 5 cycles in S_HOLD -> if_pc/if_inst unchanged, no new Inst_Req_Valid.
- Redirect to 0x100 in S_WAIT, response arrives 2 cycles later -> response dropped, next request PC=0x100, if_valid never shows stale inst.
- Redirect to 0x200 in S_HOLD with if_ready=1 same cycle -> next PC=0x200, not if_pc+4.
- RESET_PC=32'hFFFF_FFFC, two sequential fetches -> second if_pc=0x0000_0000.
- rst asserted in S_WAIT -> outputs at reset values same cycle, restart fetch at RESET_PC; with FETCH_PERF_CNT_EN, fetch_cycles returns to 0.
